// File: rtl/rv32i_types.sv
// ---------------------------------------------------------------------------
// rv32i_types
// Shared types for the instruction-side read cache.
//   cache_state_t : controller states (IDLE, MISS, FLUSH)
//   WORD_BITS     : width of the word returned to the fetch unit
// The stage register struct depends on the cache geometry, so it is declared
// inside cache_read_param, where the geometry parameters are visible.
// ---------------------------------------------------------------------------
package rv32i_types;

    localparam int WORD_BITS = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MISS  = 2'd1,
        FLUSH = 2'd2
    } cache_state_t;

endpackage

// File: rtl/cache_read_param_plru.sv
// ---------------------------------------------------------------------------
// plru_tree
// Combinational tree pseudo-LRU helper for one set.
//   bits       in  WAYS-1       heap-ordered tree bits (node n -> 2n+1, 2n+2)
//   access_way in  log2(WAYS)   way being accessed this cycle
//   victim_way out log2(WAYS)   way the tree currently points at
//   new_bits   out WAYS-1       tree bits after accessing access_way
// A bit of 0 means the victim lies in the left subtree. An access sets every
// node on its path so that it points away from the accessed way.
// ---------------------------------------------------------------------------
module plru_tree #(
    parameter int WAYS = 4
) (
    input  logic [WAYS-2:0]         bits,
    input  logic [$clog2(WAYS)-1:0] access_way,
    output logic [$clog2(WAYS)-1:0] victim_way,
    output logic [WAYS-2:0]         new_bits
);
    localparam int LVL = $clog2(WAYS);

    // Walk from the root following the stored bits; each step yields one
    // victim-way bit, MSB first.
    always_comb begin
        int node;
        node       = 0;
        victim_way = '0;
        for (int l = 0; l < LVL; l++) begin
            victim_way[LVL-1-l] = bits[node];
            node = 2 * node + 1 + (bits[node] ? 1 : 0);
        end
    end

    // Walk the accessed way's path and point each node at the other side.
    always_comb begin
        int  node;
        logic dir;
        node     = 0;
        dir      = 1'b0;
        new_bits = bits;
        for (int l = 0; l < LVL; l++) begin
            dir            = access_way[LVL-1-l];
            new_bits[node] = ~dir;
            node           = 2 * node + 1 + (dir ? 1 : 0);
        end
    end

endmodule

// File: rtl/cache_read_param.sv
// ---------------------------------------------------------------------------
// cache_read_param
// Blocking, read-only, set-associative instruction cache with flop storage,
// tree-PLRU replacement (invalid ways first), pipelined single-cycle hits,
// critical-word forwarding on fill and a whole-cache flush.
//   clk, rst            clock, synchronous active-high reset
//   ufp_addr/ufp_rmask  fetch request (rmask != 0 means valid)
//   ufp_ready           request is captured at the edge when rmask != 0
//   ufp_rdata/ufp_resp  returned word and its one-cycle valid pulse
//   dfp_addr/dfp_read   line-aligned fill request, held until dfp_resp
//   dfp_write           always 0
//   dfp_rdata/dfp_resp  fill line and its one-cycle valid pulse
//   flush/flush_done    invalidate-all request and completion pulse
// ---------------------------------------------------------------------------
module cache_read_param
    import rv32i_types::*;
#(
    parameter int WAYS      = 4,
    parameter int SETS      = 16,
    parameter int LINE_BITS = 256,
    parameter int ADDR_BITS = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_BITS-1:0] ufp_addr,
    input  logic [3:0]           ufp_rmask,
    output logic                 ufp_ready,
    output logic [31:0]          ufp_rdata,
    output logic                 ufp_resp,
    output logic [ADDR_BITS-1:0] dfp_addr,
    output logic                 dfp_read,
    output logic                 dfp_write,
    input  logic [LINE_BITS-1:0] dfp_rdata,
    input  logic                 dfp_resp,
    input  logic                 flush,
    output logic                 flush_done
);
    localparam int OFS   = $clog2(LINE_BITS / 8);
    localparam int IDX   = $clog2(SETS);
    localparam int TAG   = ADDR_BITS - IDX - OFS;
    localparam int WPL   = LINE_BITS / WORD_BITS;
    localparam int WOFS  = $clog2(WPL);
    localparam int WAY_W = $clog2(WAYS);

    typedef struct packed {
        logic [TAG-1:0]  tag;
        logic [IDX-1:0]  idx;
        logic [WOFS-1:0] wofs;
        logic            valid;
    } stage_t;

    cache_state_t         r_state, w_state_next;
    stage_t               r_stage;
    logic                 r_flush_pending;
    logic [IDX-1:0]       r_flush_cnt;
    logic [WAYS-1:0]      r_valid [SETS];
    logic [WAYS-2:0]      r_plru  [SETS];
    logic [TAG-1:0]       r_tag   [SETS][WAYS];
    logic [LINE_BITS-1:0] r_data  [SETS][WAYS];

    logic [WAYS-1:0]  w_hit_vec, w_inv_vec;
    logic [WAY_W-1:0] w_hit_way, w_inv_way, w_plru_victim, w_fill_way, w_access_way;
    logic [WAYS-2:0]  w_plru_new;
    logic             w_lookup, w_hit, w_miss, w_fill, w_flush_last;

    genvar gi;
    generate
        for (gi = 0; gi < WAYS; gi++) begin : g_way
            assign w_hit_vec[gi] = r_valid[r_stage.idx][gi] && (r_tag[r_stage.idx][gi] == r_stage.tag);
            assign w_inv_vec[gi] = !r_valid[r_stage.idx][gi];
        end
    endgenerate

    // Tags are unique within a set, so the hit vector is at most one-hot.
    always_comb begin
        w_hit_way = '0;
        for (int w = 0; w < WAYS; w++)
            if (w_hit_vec[w]) w_hit_way = WAY_W'(w);
    end

    // Lowest-index invalid way wins: scan downward so the last write is lowest.
    always_comb begin
        w_inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--)
            if (w_inv_vec[w]) w_inv_way = WAY_W'(w);
    end

    assign w_lookup     = (r_state == IDLE) && r_stage.valid;
    assign w_hit        = w_lookup && (|w_hit_vec);
    assign w_miss       = w_lookup && !(|w_hit_vec);
    assign w_fill       = (r_state == MISS) && dfp_resp;
    assign w_flush_last = (r_state == FLUSH) && (r_flush_cnt == IDX'(SETS - 1));
    assign w_fill_way   = (|w_inv_vec) ? w_inv_way : w_plru_victim;
    assign w_access_way = w_fill ? w_fill_way : w_hit_way;

    plru_tree #(.WAYS(WAYS)) u_plru (
        .bits       (r_plru[r_stage.idx]),
        .access_way (w_access_way),
        .victim_way (w_plru_victim),
        .new_bits   (w_plru_new)
    );

    // Outputs
    assign ufp_ready  = !rst && (r_state == IDLE) && !r_flush_pending && (!r_stage.valid || w_hit);
    assign ufp_resp   = w_hit || w_fill;
    assign dfp_read   = (r_state == MISS);
    assign dfp_write  = 1'b0;
    assign dfp_addr   = (r_state == MISS) ? {r_stage.tag, r_stage.idx, {OFS{1'b0}}} : '0;
    assign flush_done = w_flush_last;

    always_comb begin
        ufp_rdata = '0;
        if (w_hit)
            ufp_rdata = r_data[r_stage.idx][w_hit_way][r_stage.wofs*WORD_BITS +: WORD_BITS];
        else if (w_fill)
            ufp_rdata = dfp_rdata[r_stage.wofs*WORD_BITS +: WORD_BITS];
    end

    // Next state. A pending flush waits for the stage to drain; a miss in the
    // stage always goes first so an in-flight request is never dropped.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (w_miss) w_state_next = MISS;
                     else if (r_flush_pending && (!r_stage.valid || w_hit)) w_state_next = FLUSH;
            MISS:    if (dfp_resp) w_state_next = IDLE;
            FLUSH:   if (w_flush_last) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= IDLE;
            r_stage         <= '0;
            r_flush_pending <= 1'b0;
            r_flush_cnt     <= '0;
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_plru[s]  <= '0;
            end
        end else begin
            r_state <= w_state_next;

            if (ufp_ready && (ufp_rmask != 4'h0))
                r_stage <= '{tag:   ufp_addr[ADDR_BITS-1 -: TAG],
                             idx:   ufp_addr[OFS +: IDX],
                             wofs:  ufp_addr[2 +: WOFS],
                             valid: 1'b1};
            else if (w_hit || w_fill)
                r_stage.valid <= 1'b0;

            // While flushing, only a flush still requested on the final set
            // re-arms; otherwise any sampled request is remembered.
            if (r_state == FLUSH)
                r_flush_pending <= w_flush_last && flush;
            else if (w_state_next == FLUSH)
                r_flush_pending <= 1'b0;
            else if (flush)
                r_flush_pending <= 1'b1;

            if (r_state == FLUSH)
                r_flush_cnt <= r_flush_cnt + 1'b1;

            if (w_fill) begin
                r_valid[r_stage.idx][w_fill_way] <= 1'b1;
                r_plru[r_stage.idx]              <= w_plru_new;
            end else if (w_hit) begin
                r_plru[r_stage.idx] <= w_plru_new;
            end else if (r_state == FLUSH) begin
                r_valid[r_flush_cnt] <= '0;
                r_plru[r_flush_cnt]  <= '0;
            end
        end
    end

    // Tag and data arrays carry no reset; the valid bits qualify them.
    always_ff @(posedge clk) begin
        if (!rst && w_fill) begin
            r_tag[r_stage.idx][w_fill_way]  <= r_stage.tag;
            r_data[r_stage.idx][w_fill_way] <= dfp_rdata;
        end
    end

endmodule

// File: tb/tb_cache_read_param.sv
// ---------------------------------------------------------------------------
// tb_cache_read_param
// Directed bench for two cache configurations: the default 4-way/16-set/256-bit
// cache (sel=0) and a 2-way/8-set/128-bit variant (sel=1). Expected words are
// queued when a request is issued and compared when the response arrives.
// Fill data: word i of the line at address L is L + 0xA0 + i - 0x1000.
// ---------------------------------------------------------------------------
module tb_cache_read_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst = 1'b1;
    logic         sel = 1'b0;
    logic [31:0]  ufp_addr = '0;
    logic [3:0]   rmask = '0;
    logic         flush = 1'b0;
    logic [255:0] dfp_line = '0;
    logic         dfp_resp_drv = 1'b0;

    logic [3:0]  rmask0, rmask1;
    logic        flush0, flush1, dresp0, dresp1;
    logic        ready0, resp0, dread0, dwrite0, fdone0;
    logic        ready1, resp1, dread1, dwrite1, fdone1;
    logic [31:0] rdata0, daddr0, rdata1, daddr1;

    assign rmask0 = sel ? 4'h0 : rmask;
    assign rmask1 = sel ? rmask : 4'h0;
    assign flush0 = flush & ~sel;
    assign flush1 = flush & sel;
    assign dresp0 = dfp_resp_drv & ~sel;
    assign dresp1 = dfp_resp_drv & sel;

    logic        cur_ready, cur_resp, cur_dread, cur_dwrite, cur_fdone;
    logic [31:0] cur_rdata, cur_daddr;
    assign cur_ready  = sel ? ready1  : ready0;
    assign cur_resp   = sel ? resp1   : resp0;
    assign cur_dread  = sel ? dread1  : dread0;
    assign cur_dwrite = sel ? dwrite1 : dwrite0;
    assign cur_fdone  = sel ? fdone1  : fdone0;
    assign cur_rdata  = sel ? rdata1  : rdata0;
    assign cur_daddr  = sel ? daddr1  : daddr0;

    cache_read_param dut0 (
        .clk(clk), .rst(rst), .ufp_addr(ufp_addr), .ufp_rmask(rmask0),
        .ufp_ready(ready0), .ufp_rdata(rdata0), .ufp_resp(resp0),
        .dfp_addr(daddr0), .dfp_read(dread0), .dfp_write(dwrite0),
        .dfp_rdata(dfp_line), .dfp_resp(dresp0),
        .flush(flush0), .flush_done(fdone0)
    );

    cache_read_param #(.WAYS(2), .SETS(8), .LINE_BITS(128), .ADDR_BITS(32)) dut1 (
        .clk(clk), .rst(rst), .ufp_addr(ufp_addr), .ufp_rmask(rmask1),
        .ufp_ready(ready1), .ufp_rdata(rdata1), .ufp_resp(resp1),
        .dfp_addr(daddr1), .dfp_read(dread1), .dfp_write(dwrite1),
        .dfp_rdata(dfp_line[127:0]), .dfp_resp(dresp1),
        .flush(flush1), .flush_done(fdone1)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] fill_word(input logic [31:0] line, input int i);
        return line + 32'h0000_00A0 + 32'(i) - 32'h0000_1000;
    endfunction

    function automatic logic [255:0] mk_line(input logic [31:0] line);
        logic [255:0] l;
        l = '0;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = fill_word(line, i);
        return l;
    endfunction

    function automatic logic [31:0] line_of(input logic [31:0] a);
        logic [31:0] lb;
        lb = sel ? 32'd16 : 32'd32;
        return a & ~(lb - 32'd1);
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] a);
        return fill_word(line_of(a), int'((a - line_of(a)) >> 2));
    endfunction

    // ---------------- memory-side responder (fill after a short delay) ----
    int          miss_cnt = 0;
    logic [31:0] last_dfp_addr = '0;
    bit          stray_tog = 1'b0;

    initial begin
        bit pending;
        bit stray_seen;
        int wait_cnt;
        pending    = 1'b0;
        stray_seen = 1'b0;
        wait_cnt   = 0;
        forever begin
            @(posedge clk); #2;
            dfp_resp_drv = 1'b0;
            if (rst) begin
                pending = 1'b0;
            end else if (stray_tog != stray_seen) begin
                stray_seen   = stray_tog;
                dfp_line     = mk_line(32'h0000_7000);
                dfp_resp_drv = 1'b1;
            end else if (cur_dread && !pending) begin
                pending       = 1'b1;
                wait_cnt      = 2;
                miss_cnt      = miss_cnt + 1;
                last_dfp_addr = cur_daddr;
            end else if (pending) begin
                if (wait_cnt == 0) begin
                    pending      = 1'b0;
                    dfp_line     = mk_line(cur_daddr);
                    dfp_resp_drv = cur_dread;
                end else begin
                    wait_cnt = wait_cnt - 1;
                end
            end
        end
    end

    // ---------------- response monitor ----------------
    logic [31:0] resp_data[$];
    int          resp_cyc[$];
    bit          resp_fill[$];

    always @(negedge clk) begin
        if (cur_resp) begin
            resp_data.push_back(cur_rdata);
            resp_cyc.push_back(cyc);
            resp_fill.push_back(sel ? dresp1 : dresp0);
        end
    end

    // ---------------- scoreboard and directed sequence ----------------
    int          vectors = 0;
    int          miscompares = 0;
    int          rd_idx = 0;
    logic [31:0] exp_q[$];
    int          cap_q[$];

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Present a request and hold it until captured; returns at the
    // capture edge + 1 so the next request can follow back-to-back.
    task automatic issue(input logic [31:0] a);
        int b;
        b = 0;
        ufp_addr = a;
        rmask    = 4'hF;
        while (!cur_ready && b < 100) begin step(); b++; end
        check32("capture_in_budget", 32'(b < 100), 32'd1);
        exp_q.push_back(exp_word(a));
        step();
        cap_q.push_back(cyc);
        rmask = 4'h0;
    endtask

    task automatic collect(input string tag, input bit exp_fill);
        int          b;
        int          c;
        logic [31:0] e;
        bit          got;
        b = 0;
        while (resp_data.size() <= rd_idx && b < 100) begin @(negedge clk); #1; b++; end
        e   = exp_q.pop_front();
        c   = cap_q.pop_front();
        got = (resp_data.size() > rd_idx);
        check32({tag, "_resp"}, 32'(got), 32'd1);
        if (got) begin
            $display("txn %s addr_word=%h fill=%0d cyc=%0d", tag, resp_data[rd_idx], resp_fill[rd_idx], resp_cyc[rd_idx]);
            check32({tag, "_data"}, resp_data[rd_idx], e);
            check32({tag, "_fill"}, 32'(resp_fill[rd_idx]), 32'(exp_fill));
            if (!exp_fill) check32({tag, "_latency"}, 32'(resp_cyc[rd_idx] - c + 1), 32'd1);
            rd_idx++;
        end
    endtask

    task automatic rd(input logic [31:0] a, input bit exp_miss, input string tag);
        int m0;
        m0 = miss_cnt;
        step();
        issue(a);
        collect(tag, exp_miss);
        check32({tag, "_miss"}, 32'(miss_cnt - m0), 32'(exp_miss));
        if (exp_miss) check32({tag, "_dfp_addr"}, last_dfp_addr, line_of(a));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        step();
    endtask

    logic [31:0] ev_addr[9] = '{32'h000, 32'h200, 32'h400, 32'h600, 32'h000, 32'h800, 32'h400, 32'h000, 32'h600};
    bit          ev_miss[9] = '{1, 1, 1, 1, 0, 1, 1, 0, 0};
    logic [31:0] v_addr[8]  = '{32'h020, 32'h0A0, 32'h020, 32'h120, 32'h020, 32'h0A0, 32'h020, 32'h120};
    bit          v_miss[8]  = '{1, 1, 0, 1, 0, 1, 0, 1};

    initial begin
        int b0, m0, low, done, b;

        // Reset state, observed while reset is held.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check32("rst_ready",      32'(cur_ready), 32'd0);
        check32("rst_resp",       32'(cur_resp),  32'd0);
        check32("rst_dfp_read",   32'(cur_dread), 32'd0);
        check32("rst_flush_done", 32'(cur_fdone), 32'd0);
        check32("rst_dfp_addr",   cur_daddr, 32'd0);
        check32("rst_rdata",      cur_rdata, 32'd0);
        step();
        rst = 1'b0;
        step();
        check32("post_rst_ready", 32'(cur_ready), 32'd1);

        // Cold miss with critical-word forwarding, then a hit in the same line.
        rd(32'h1004, 1'b1, "cold_miss");
        rd(32'h1008, 1'b0, "line_hit");

        // Eight back-to-back hits.
        step();
        b0 = rd_idx;
        m0 = miss_cnt;
        for (int k = 0; k < 8; k++) begin
            check32("burst_ready", 32'(cur_ready), 32'd1);
            issue(32'h1000 + 32'(4 * k));
        end
        for (int k = 0; k < 8; k++) collect("burst", 1'b0);
        check32("burst_span", 32'(resp_cyc[b0 + 7] - resp_cyc[b0]), 32'd7);
        check32("burst_miss", 32'(miss_cnt - m0), 32'd0);

        // A zero mask captures nothing.
        step();
        ufp_addr = 32'h5000;
        rmask    = 4'h0;
        m0 = miss_cnt;
        repeat (5) step();
        check32("rmask0_no_resp", 32'(resp_data.size()), 32'(rd_idx));
        check32("rmask0_no_miss", 32'(miss_cnt - m0), 32'd0);

        // Same-line back-to-back miss: second access hits after the fill.
        step();
        m0 = miss_cnt;
        issue(32'h2000);
        issue(32'h2004);
        collect("same_line_a", 1'b1);
        collect("same_line_b", 1'b0);
        check32("same_line_miss", 32'(miss_cnt - m0), 32'd1);

        // Flush: one pending cycle plus one cycle per set with ready low.
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        low  = 0;
        done = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (!cur_ready) low++;
            if (cur_fdone) done++;
        end
        check32("flush_ready_low", 32'(low), 32'd17);
        check32("flush_done_once", 32'(done), 32'd1);
        rd(32'h1000, 1'b1, "post_flush");

        // Reset while a miss is outstanding, followed by a stray fill pulse.
        step();
        issue(32'h3000);
        b = 0;
        while (!cur_dread && b < 20) begin step(); b++; end
        check32("midmiss_dfp_read", 32'(cur_dread), 32'd1);
        check32("dfp_write_zero",   32'(cur_dwrite), 32'd0);
        rst = 1'b1;
        step();
        check32("midmiss_read_drop", 32'(cur_dread), 32'd0);
        rst = 1'b0;
        void'(exp_q.pop_front());
        void'(cap_q.pop_front());
        stray_tog = ~stray_tog;
        repeat (4) step();
        check32("stray_no_resp",  32'(resp_data.size()), 32'(rd_idx));
        check32("stray_dfp_read", 32'(cur_dread), 32'd0);
        rd(32'h3000, 1'b1, "after_rst_same");
        rd(32'h1000, 1'b1, "after_rst_old");

        // PLRU eviction in the default configuration.
        do_reset();
        for (int k = 0; k < 9; k++) rd(ev_addr[k], ev_miss[k], "evict4");

        // Variant configuration.
        sel = 1'b1;
        do_reset();
        rd(32'h1004, 1'b1, "v_cold");
        rd(32'h1008, 1'b0, "v_hit");
        for (int k = 0; k < 8; k++) rd(v_addr[k], v_miss[k], "evict2");

        step();
        check32("no_extra_resp", 32'(resp_data.size()), 32'(rd_idx));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
